// File: rtl/hub75_pkg.sv
// Purpose : shared widths, FSM encoding and address layout for the HUB75 frame-buffer readout.
// Latency : n/a (declarations only).
// Backpress: n/a.
// Contents: default geometry, pixel-word width helper, bank-count log helper, FSM state codes.
// Frame-memory address layout is {bank, row, col} with col in the LSBs.
package hub75_pkg;

   localparam int DEF_N_BANKS  = 2;
   localparam int DEF_N_ROWS   = 32;
   localparam int DEF_N_COLS   = 64;
   localparam int DEF_N_CHANS  = 3;
   localparam int DEF_N_PLANES = 8;

   // FSM encoding, kept as plain constants so older tools can consume them
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_READY = 2'd3;

   // one pixel word: all channels of one pixel, channel c at [c*n_planes +: n_planes]
   function automatic int pix_w(input int n_chans, input int n_planes);
      return n_chans * n_planes;
   endfunction

   // a single bank still needs a 1-bit bank field in the address
   function automatic int log_banks(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hub75_fb_readout_if.sv
// Purpose : bundles the scan-controller, shifter and frame-memory signals of the readout.
// Latency : n/a (wires only).
// Backpress: fbm_gnt stalls frame-memory fetches; scan side uses load/rdy/swap pulses.
// Ports   : slave = readout block, master = its surroundings (scan ctrl, shifter, memory arbiter).
interface hub75_fb_readout_if
   import hub75_pkg::*;
#(
   parameter int N_BANKS  = DEF_N_BANKS,
   parameter int N_ROWS   = DEF_N_ROWS,
   parameter int N_COLS   = DEF_N_COLS,
   parameter int N_CHANS  = DEF_N_CHANS,
   parameter int N_PLANES = DEF_N_PLANES
);
   localparam int LOG_N_BANKS = log_banks(N_BANKS);
   localparam int LOG_N_ROWS  = $clog2(N_ROWS);
   localparam int LOG_N_COLS  = $clog2(N_COLS);
   localparam int PIX_W       = pix_w(N_CHANS, N_PLANES);

   // scan controller side
   logic [LOG_N_ROWS-1:0]                     fb_row_addr;
   logic                                      fb_row_load;
   logic                                      fb_row_rdy;
   logic                                      fb_row_swap;
   // shifter side
   logic [LOG_N_COLS-1:0]                     fbr_col_addr;
   logic                                      fbr_rden;
   logic [N_BANKS*PIX_W-1:0]                  fbr_data;
   // frame memory side
   logic [LOG_N_BANKS+LOG_N_ROWS+LOG_N_COLS-1:0] fbm_addr;
   logic                                      fbm_req;
   logic                                      fbm_gnt;
   logic [PIX_W-1:0]                          fbm_data;

   modport slave (
      input  fb_row_addr, fb_row_load, fb_row_swap, fbr_col_addr, fbr_rden, fbm_gnt, fbm_data,
      output fb_row_rdy, fbr_data, fbm_addr, fbm_req
   );

   modport master (
      output fb_row_addr, fb_row_load, fb_row_swap, fbr_col_addr, fbr_rden, fbm_gnt, fbm_data,
      input  fb_row_rdy, fbr_data, fbm_addr, fbm_req
   );

endinterface

// File: rtl/hub75_linebuf_ram.sv
// Purpose : simple dual-port line-buffer RAM (one write port, one read port).
// Latency : read data registered, valid 1 cycle after rd_en_i; held while rd_en_i=0.
// Backpress: none; every enabled access completes.
// Ports   : clk/rst, wr_en_i/wr_addr_i/wr_dat_i write port, rd_en_i/rd_addr_i read port, rd_dat_o.
module hub75_linebuf_ram #(
   parameter int AW = 7,
   parameter int W  = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_dat_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_dat_o
);

   logic [W-1:0] mem [2**AW];
   logic [W-1:0] rd_dat_q;

   // storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_dat_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rd_dat_q <= '0;
      else if (rd_en_i) rd_dat_q <= mem[rd_addr_i];
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/hub75_fb_readout.sv
// Purpose : fetches one row (all banks) from frame memory into the back half of a ping-pong line buffer, swaps on command.
// Latency : N_BANKS*N_COLS+2 cycles load->rdy with continuous grant; front read data 1 cycle after fbr_rden.
// Backpress: fbm_gnt=0 holds address and counters; load/swap pulses outside their legal states are dropped.
// Ports   : clk, rst (async, active high), bus (hub75_fb_readout_if.slave).
module hub75_fb_readout
   import hub75_pkg::*;
#(
   parameter int N_BANKS  = DEF_N_BANKS,
   parameter int N_ROWS   = DEF_N_ROWS,
   parameter int N_COLS   = DEF_N_COLS,
   parameter int N_CHANS  = DEF_N_CHANS,
   parameter int N_PLANES = DEF_N_PLANES
) (
   input  logic               clk,
   input  logic               rst,
   hub75_fb_readout_if.slave  bus
);

   localparam int LOG_N_BANKS = log_banks(N_BANKS);
   localparam int LOG_N_ROWS  = $clog2(N_ROWS);
   localparam int LOG_N_COLS  = $clog2(N_COLS);
   localparam int PIX_W       = pix_w(N_CHANS, N_PLANES);

   localparam logic [LOG_N_BANKS-1:0] LAST_BANK = LOG_N_BANKS'(N_BANKS - 1);
   localparam logic [LOG_N_COLS-1:0]  LAST_COL  = LOG_N_COLS'(N_COLS - 1);

   logic [1:0]             state_q, state_d;
   logic [LOG_N_ROWS-1:0]  row_q, row_d;
   logic [LOG_N_BANKS-1:0] bank_q, bank_d;
   logic [LOG_N_COLS-1:0]  col_q, col_d;
   logic                   front_sel_q, front_sel_d;
   logic                   rdy_q;

   // granted fetch delayed to line up with fbm_data
   logic                   wr_vld_q;
   logic [LOG_N_BANKS-1:0] wr_bank_q;
   logic [LOG_N_COLS-1:0]  wr_col_q;

   logic [PIX_W-1:0]       rd_dat [N_BANKS];

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      bank_d      = bank_q;
      col_d       = col_q;
      front_sel_d = front_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.fb_row_load) begin
               state_d = ST_LOAD;
               row_d   = bus.fb_row_addr;
               bank_d  = '0;
               col_d   = '0;
            end
         end
         ST_LOAD: begin
            if (bus.fbm_gnt) begin
               col_d = col_q + LOG_N_COLS'(1);
               if (col_q == LAST_COL) begin
                  if (bank_q == LAST_BANK) begin
                     bank_d  = '0;
                     state_d = ST_DRAIN;
                  end else begin
                     bank_d = bank_q + LOG_N_BANKS'(1);
                  end
               end
            end
         end
         ST_DRAIN: state_d = ST_READY;
         ST_READY: begin
            // swap first; a simultaneous load then fills the new back half (old front)
            if (bus.fb_row_swap) begin
               front_sel_d = ~front_sel_q;
               state_d     = ST_IDLE;
            end
            if (bus.fb_row_load) begin
               state_d = ST_LOAD;
               row_d   = bus.fb_row_addr;
               bank_d  = '0;
               col_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         bank_q      <= '0;
         col_q       <= '0;
         front_sel_q <= 1'b0;
         rdy_q       <= 1'b0;
         wr_vld_q    <= 1'b0;
         wr_bank_q   <= '0;
         wr_col_q    <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         bank_q      <= bank_d;
         col_q       <= col_d;
         front_sel_q <= front_sel_d;
         rdy_q       <= (state_d == ST_READY);
         wr_vld_q    <= (state_q == ST_LOAD) && bus.fbm_gnt;
         wr_bank_q   <= bank_q;
         wr_col_q    <= col_q;
      end
   end

   // request is decoded from state so an async reset drops it immediately
   assign bus.fbm_req    = (state_q == ST_LOAD);
   assign bus.fbm_addr   = {bank_q, row_q, col_q};
   assign bus.fb_row_rdy = rdy_q;

   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      hub75_linebuf_ram #(
         .AW (LOG_N_COLS + 1),
         .W  (PIX_W)
      ) u_ram (
         .clk       (clk),
         .rst       (rst),
         .wr_en_i   (wr_vld_q && (wr_bank_q == LOG_N_BANKS'(b))),
         .wr_addr_i ({~front_sel_q, wr_col_q}),
         .wr_dat_i  (bus.fbm_data),
         .rd_en_i   (bus.fbr_rden),
         .rd_addr_i ({front_sel_q, bus.fbr_col_addr}),
         .rd_dat_o  (rd_dat[b])
      );
   end

   always_comb begin
      bus.fbr_data = '0;
      for (int b = 0; b < N_BANKS; b++) bus.fbr_data[b*PIX_W +: PIX_W] = rd_dat[b];
   end

endmodule

// File: tb/tb_hub75_fb_readout.sv
// Purpose : self-checking bench for hub75_fb_readout (default geometry).
// Latency : n/a.
// Backpress: memory model grants continuously or randomly; returns the zero-extended address 1 cycle later.
module tb_hub75_fb_readout;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hub75_fb_readout_if bus ();

   hub75_fb_readout dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit stall_mode = 1'b0;

   // frame memory: word at address A is A itself; non-granted cycles return junk
   always @(posedge clk)
      bus.fbm_data <= (bus.fbm_req && bus.fbm_gnt) ? 24'(bus.fbm_addr) : 24'($urandom);

   // reference pixel word of bank b, row r, column c
   function automatic logic [23:0] exp_word(input int b, input int r, input int c);
      return 24'(b * 32 * 64 + r * 64 + c);
   endfunction

   function automatic logic [47:0] exp_line(input int r, input int c);
      logic [47:0] v;
      v[23:0]  = exp_word(0, r, c);
      v[47:24] = exp_word(1, r, c);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      logic        p_req, p_gnt;
      logic [11:0] p_addr;
      p_req  = bus.fbm_req;
      p_gnt  = bus.fbm_gnt;
      p_addr = bus.fbm_addr;
      @(posedge clk);
      #1;
      if (p_req && !p_gnt && bus.fbm_req) chk("addr_hold_on_stall", bus.fbm_addr, p_addr);
      bus.fbm_gnt = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic start_load(input int r);
      bus.fb_row_addr = 5'(r);
      bus.fb_row_load = 1'b1;
      tick();
      bus.fb_row_load = 1'b0;
   endtask

   task automatic wait_rdy(output int n);
      n = 0;
      while (!bus.fb_row_rdy && n < 2000) begin
         tick();
         n++;
      end
      chk("rdy_reached", bus.fb_row_rdy, 1);
   endtask

   task automatic swap();
      bus.fb_row_swap = 1'b1;
      tick();
      bus.fb_row_swap = 1'b0;
   endtask

   task automatic read_col(input int c, output logic [47:0] d);
      bus.fbr_rden     = 1'b1;
      bus.fbr_col_addr = 6'(c);
      tick();
      bus.fbr_rden = 1'b0;
      d = bus.fbr_data;
   endtask

   typedef struct {
      logic [4:0]  row;
      logic [5:0]  col;
      bit          stall;
      logic [47:0] exp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int          n, lat, r, c, front_row;
      logic [47:0] d;

      vecs[0] = '{5'd0,  6'd0,  1'b0, 48'h000800_000000};
      vecs[1] = '{5'd31, 6'd63, 1'b0, 48'h000FFF_0007FF};
      vecs[2] = '{5'd6,  6'd10, 1'b1, 48'h00098A_00018A};
      vecs[3] = '{5'd17, 6'd32, 1'b1, 48'h000C60_000460};

      bus.fb_row_addr  = '0;
      bus.fb_row_load  = 1'b0;
      bus.fb_row_swap  = 1'b0;
      bus.fbr_col_addr = '0;
      bus.fbr_rden     = 1'b0;
      bus.fbm_gnt      = 1'b1;

      // reset state
      tick();
      tick();
      chk("rst_rdy",      bus.fb_row_rdy, 0);
      chk("rst_req",      bus.fbm_req,    0);
      chk("rst_addr",     bus.fbm_addr,   0);
      chk("rst_fbr_data", bus.fbr_data,   0);
      rst = 1'b0;
      tick();

      // basic load of row 5 with explicit bit placement
      start_load(5);
      wait_rdy(n);
      chk("basic_latency", n + 1, 130);
      swap();
      chk("basic_rdy_clr", bus.fb_row_rdy, 0);
      read_col(3, d);
      chk("basic_bank0_bits", d[23:0],  24'h000143);
      chk("basic_bank1_bits", d[47:24], 24'h000943);

      // swap + load together: front shows row 5 while row 6 fills the other half
      start_load(5);
      wait_rdy(n);
      bus.fb_row_swap = 1'b1;
      bus.fb_row_load = 1'b1;
      bus.fb_row_addr = 5'd6;
      tick();
      bus.fb_row_swap = 1'b0;
      bus.fb_row_load = 1'b0;
      chk("pipe_rdy_clr", bus.fb_row_rdy, 0);
      chk("pipe_req",     bus.fbm_req,    1);
      lat = 1;
      for (int k = 0; k < 8; k++) begin
         read_col(k * 9, d);
         chk("pipe_front_row5", d, exp_line(5, k * 9));
         lat++;
      end
      wait_rdy(n);
      chk("pipe_latency", lat + n, 130);
      swap();
      read_col(40, d);
      chk("pipe_front_row6", d, exp_line(6, 40));

      // swap and load during LOAD are ignored
      start_load(7);
      lat = 1;
      repeat (10) begin
         tick();
         lat++;
      end
      bus.fb_row_swap = 1'b1;
      bus.fb_row_load = 1'b1;
      bus.fb_row_addr = 5'd9;
      tick();
      lat++;
      bus.fb_row_swap = 1'b0;
      bus.fb_row_load = 1'b0;
      wait_rdy(n);
      chk("illegal_latency", lat + n, 130);
      read_col(0, d);
      chk("illegal_front_kept", d, exp_line(6, 0));
      swap();
      read_col(1, d);
      chk("illegal_row_not_relatched", d, exp_line(7, 1));

      // read latency and hold
      read_col(63, d);
      chk("rd_col63", d, exp_line(7, 63));
      for (int k = 0; k < 5; k++) begin
         bus.fbr_col_addr = 6'($urandom);
         tick();
         chk("rd_hold", bus.fbr_data, exp_line(7, 63));
      end

      // table-driven load / swap / read vectors
      for (int i = 0; i < 4; i++) begin
         stall_mode = vecs[i].stall;
         start_load(int'(vecs[i].row));
         wait_rdy(n);
         if (!vecs[i].stall) chk("vec_latency", n + 1, 130);
         stall_mode = 1'b0;
         swap();
         chk("vec_rdy_clr", bus.fb_row_rdy, 0);
         read_col(int'(vecs[i].col), d);
         chk("vec_data", d, vecs[i].exp);
      end

      // randomized: loads with random stalls, restarts in READY, stray swaps in IDLE
      for (int it = 0; it < 8; it++) begin
         r = $urandom_range(0, 31);
         stall_mode = 1'($urandom_range(0, 1));
         start_load(r);
         wait_rdy(n);
         if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 31);
            start_load(r);
            chk("rnd_restart_rdy_clr", bus.fb_row_rdy, 0);
            wait_rdy(n);
         end
         stall_mode = 1'b0;
         swap();
         front_row = r;
         if ($urandom_range(0, 1) == 1) swap();
         for (int k = 0; k < 4; k++) begin
            c = $urandom_range(0, 63);
            read_col(c, d);
            chk("rnd_front", d, exp_line(front_row, c));
         end
      end

      // async reset in the middle of a load
      start_load(12);
      n = 0;
      while (bus.fbm_addr[5:0] != 6'd20 && n < 200) begin
         tick();
         n++;
      end
      chk("mid_load_col20", bus.fbm_addr[5:0], 20);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_req",  bus.fbm_req,    0);
      chk("arst_rdy",  bus.fb_row_rdy, 0);
      chk("arst_addr", bus.fbm_addr,   0);
      tick();
      rst = 1'b0;
      tick();
      start_load(12);
      wait_rdy(n);
      chk("post_rst_latency", n + 1, 130);
      swap();
      read_col(20, d);
      chk("post_rst_data", d, exp_line(12, 20));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
